// File: rtl/sha256_iter_core.sv
// sha256_iter_core: iterative SHA-256 compression core.
// ROUNDS_PER_CYCLE (1, 2, 4 or 8) rounds are unrolled per clock.
// A 16-word sliding window produces the message schedule.
// Optional feature: define SHA256_ITER_SHA224_EN to add the mode224 port.
// That port selects the SHA-224 IV and a truncated 224-bit digest.
module sha256_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_data,
  input  logic         first_block,
`ifdef SHA256_ITER_SHA224_EN
  input  logic         mode224,
`endif
  output logic [255:0] hash_out,
  output logic         hash_valid,
  output logic         busy
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam int         R        = ROUNDS_PER_CYCLE;
  localparam logic [6:0] LAST_CNT = 7'(64 - R);
  localparam logic [6:0] CNT_STEP = 7'(R);

  generate
    if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
      $error("sha256_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV_256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA256_ITER_SHA224_EN
  localparam word_t IV_224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_t       state;
  state_t       state_nxt;
  logic [6:0]   rnd_cnt;
  word_t        w_reg [16];
  word_t        v_reg [8];
  word_t        h_reg [8];
  logic         accept;

  word_t        ws [R+1][16];
  word_t        vs [R+1][8];
  word_t        t1 [R];
  word_t        t2 [R];
  word_t        iv_sel [8];
  word_t        h_sum [8];
  logic [255:0] hash_nxt;

  assign accept = block_valid && block_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking assignments here would make results depend on
  // process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> ROUND on accept, ROUND -> FINAL on the last step.
  // NOTE: the default assignment first keeps this block purely combinational;
  // any path that skipped state_nxt would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (rnd_cnt == LAST_CNT) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    block_ready = (state == IDLE);
    busy        = (state != IDLE);
  end

  // Chaining IV: SHA-256 by default, SHA-224 when the mode is selected at accept.
  always_comb begin
    for (int i = 0; i < 8; i++) iv_sel[i] = IV_256[i];
`ifdef SHA256_ITER_SHA224_EN
    if (mode224) begin
      for (int i = 0; i < 8; i++) iv_sel[i] = IV_224[i];
    end
`endif
  end

  // Unrolled rounds: stage j applies round rnd_cnt+j and slides the schedule window.
  always_comb begin
    for (int i = 0; i < 16; i++) ws[0][i] = w_reg[i];
    for (int i = 0; i < 8; i++)  vs[0][i] = v_reg[i];
    for (int j = 0; j < R; j++) begin
      t1[j] = vs[j][7] + bsig1(vs[j][4]) + ch(vs[j][4], vs[j][5], vs[j][6])
            + K_TABLE[rnd_cnt[5:0] + 6'(j)] + ws[j][0];
      t2[j] = bsig0(vs[j][0]) + maj(vs[j][0], vs[j][1], vs[j][2]);
      vs[j+1][0] = t1[j] + t2[j];
      vs[j+1][1] = vs[j][0];
      vs[j+1][2] = vs[j][1];
      vs[j+1][3] = vs[j][2];
      vs[j+1][4] = vs[j][3] + t1[j];
      vs[j+1][5] = vs[j][4];
      vs[j+1][6] = vs[j][5];
      vs[j+1][7] = vs[j][6];
      for (int i = 0; i < 15; i++) ws[j+1][i] = ws[j][i+1];
      ws[j+1][15] = ssig1(ws[j][14]) + ws[j][9] + ssig0(ws[j][1]) + ws[j][0];
    end
  end

`ifdef SHA256_ITER_SHA224_EN
  logic mode_reg;

  // Digest mode, latched only when a new message starts; chained blocks keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      mode_reg <= 1'b0;
    else if (accept && first_block)  mode_reg <= mode224;
  end
`endif

  // Final feed-forward sum and the packed digest (H0 in the top word).
  always_comb begin
    hash_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_reg[i] + v_reg[i];
      hash_nxt[255 - 32*i -: 32] = h_sum[i];
    end
`ifdef SHA256_ITER_SHA224_EN
    if (mode_reg) hash_nxt[31:0] = '0;
`endif
  end

  // Datapath: load on accept, iterate in ROUND, feed forward and publish in FINAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_cnt    <= '0;
      hash_out   <= '0;
      hash_valid <= 1'b0;
      // NOTE: the schedule window and working variables are cleared explicitly
      // because a defined post-reset state is wanted; a storage array that
      // needs no defined contents would normally be left unreset.
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v_reg[i] <= '0;
        h_reg[i] <= IV_256[i];
      end
    end else begin
      hash_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rnd_cnt <= '0;
            for (int i = 0; i < 16; i++) w_reg[i] <= block_data[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              v_reg[i] <= first_block ? iv_sel[i] : h_reg[i];
              if (first_block) h_reg[i] <= iv_sel[i];
            end
          end
        end
        ROUND: begin
          rnd_cnt <= rnd_cnt + CNT_STEP;
          for (int i = 0; i < 16; i++) w_reg[i] <= ws[R][i];
          for (int i = 0; i < 8; i++)  v_reg[i] <= vs[R][i];
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_sum[i];
          hash_out   <= hash_nxt;
          hash_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
// tb_sha256_iter_core: self-checking bench for sha256_iter_core.
// Four cores run side by side, one for each of ROUNDS_PER_CYCLE = 1, 2, 4 and 8.
// Known-answer vectors come first, then randomized blocks.
// Those blocks are checked against a plain-arithmetic SHA-256 reference model.
module tb_sha256_iter_core;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
    32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_HASH   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_HASH = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_HASH   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk;
  logic         rn [4];
  logic         bv [4];
  logic         br [4];
  logic [511:0] bd [4];
  logic         fb [4];
  logic [255:0] ho [4];
  logic         hv [4];
  logic         bz [4];
`ifdef SHA256_ITER_SHA224_EN
  logic         m224 [4];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .rst_n       (rn[g]),
      .block_valid (bv[g]),
      .block_ready (br[g]),
      .block_data  (bd[g]),
      .first_block (fb[g]),
`ifdef SHA256_ITER_SHA224_EN
      .mode224     (m224[g]),
`endif
      .hash_out    (ho[g]),
      .hash_valid  (hv[g]),
      .busy        (bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, x, y, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      x = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      y = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x;
      d = c; c = b; b = a; a = x + y;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96]  + e, hin[95:64]    + f, hin[63:32]    + g, hin[31:0]     + h};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- checking and driving ----------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents one block and waits for its accept edge.
  task automatic send(input int k, input logic [511:0] data, input logic first, input string tag);
    check($sformatf("%s_ready", tag), br[k], 1'b1);
    bd[k] = data;
    fb[k] = first;
    bv[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bv[k] = 1'b0;
    check($sformatf("%s_busy", tag), bz[k], 1'b1);
    check($sformatf("%s_valid_low", tag), hv[k], 1'b0);
  endtask

  // Counts cycles after the accept edge until hash_valid; optionally pushes junk meanwhile.
  task automatic wait_hash(input int k, input int exp_lat, input logic [255:0] exp_hash,
                           input logic [255:0] prev, input bit junk, input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (hv[k]) begin
        seen  = 1'b1;
        n     = c;
        bv[k] = 1'b0;
      end else begin
        if (c == exp_lat / 2) check($sformatf("%s_hold", tag), ho[k], prev);
        if (junk) begin
          bd[k] = rand_block();
          fb[k] = 1'($urandom_range(0, 1));
          bv[k] = 1'b1;
        end
      end
    end
    check($sformatf("%s_latency", tag), n, exp_lat);
    check($sformatf("%s_hash", tag), ho[k], exp_hash);
    check($sformatf("%s_ready_at_valid", tag), br[k], 1'b1);
    check($sformatf("%s_idle_at_valid", tag), bz[k], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] model_h [4];
  bit           seeded  [4];
  logic [255:0] prev;
  logic [255:0] exp_h;
  logic [511:0] data;
  logic         first;
  bit           junk;
  bit           saw;
  int           k;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rn[i] = 1'b0; bv[i] = 1'b0; bd[i] = '0; fb[i] = 1'b0;
`ifdef SHA256_ITER_SHA224_EN
      m224[i] = 1'b0;
`endif
      model_h[i] = IV;
      seeded[i]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) rn[i] = 1'b1;
    @(negedge clk);

    // Reset state of every core.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_hash_r%0d", 1 << i), ho[i], '0);
      check($sformatf("reset_valid_r%0d", 1 << i), hv[i], 1'b0);
      check($sformatf("reset_ready_r%0d", 1 << i), br[i], 1'b1);
      check($sformatf("reset_busy_r%0d", 1 << i), bz[i], 1'b0);
    end

    // "abc" at R=1, then the pulse must drop after one cycle.
    prev = ho[0];
    send(0, ABC_BLK, 1'b1, "abc_r1");
    wait_hash(0, 65, ABC_HASH, prev, 1'b0, "abc_r1");
    @(negedge clk);
    check("abc_r1_pulse_width", hv[0], 1'b0);

    // Same block again with junk presented throughout compression.
    prev = ho[0];
    send(0, ABC_BLK, 1'b1, "junk_r1");
    wait_hash(0, 65, ABC_HASH, prev, 1'b1, "junk_r1");
    model_h[0] = ABC_HASH;

    // Empty message at R=4.
    prev = ho[2];
    send(2, EMPTY_BLK, 1'b1, "empty_r4");
    wait_hash(2, 17, EMPTY_HASH, prev, 1'b0, "empty_r4");
    model_h[2] = EMPTY_HASH;

    // Two-block message at R=2; block 2 offered in block 1's hash_valid cycle.
    prev  = ho[1];
    exp_h = compress(IV, TWO_B1);
    send(1, TWO_B1, 1'b1, "two_b1_r2");
    wait_hash(1, 33, exp_h, prev, 1'b0, "two_b1_r2");
    send(1, TWO_B2, 1'b0, "two_b2_r2");
    wait_hash(1, 33, TWO_HASH, exp_h, 1'b0, "two_b2_r2");
    model_h[1] = TWO_HASH;

    // Reset pulse in the middle of an R=8 compression.
    send(3, ABC_BLK, 1'b1, "rst_r8");
    repeat (4) @(negedge clk);
    rn[3] = 1'b0;
    #1;
    check("rst_r8_hash_cleared", ho[3], '0);
    check("rst_r8_valid_low", hv[3], 1'b0);
    check("rst_r8_ready", br[3], 1'b1);
    check("rst_r8_busy_low", bz[3], 1'b0);
    @(negedge clk);
    rn[3] = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (hv[3]) saw = 1'b1;
    end
    check("rst_r8_no_pulse", saw, 1'b0);
    check("rst_r8_hash_still_zero", ho[3], '0);
    send(3, ABC_BLK, 1'b1, "rerun_r8");
    wait_hash(3, 9, ABC_HASH, '0, 1'b0, "rerun_r8");
    model_h[3] = ABC_HASH;

`ifdef SHA256_ITER_SHA224_EN
    // SHA-224 "abc" on the R=1 core.
    m224[0] = 1'b1;
    prev    = ho[0];
    send(0, ABC_BLK, 1'b1, "sha224_r1");
    m224[0] = 1'b0;
    wait_hash(0, 65, 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000,
              prev, 1'b0, "sha224_r1");
`endif

    // Randomized blocks over all cores; the first one per core starts a new message.
    for (int i = 0; i < 4; i++) seeded[i] = 1'b0;
    for (int it = 0; it < 24; it++) begin
      k     = $urandom_range(0, 3);
      first = seeded[k] ? 1'($urandom_range(0, 1)) : 1'b1;
      seeded[k] = 1'b1;
      data  = rand_block();
      exp_h = compress(first ? IV : model_h[k], data);
      junk  = ($urandom_range(0, 3) == 0);
      prev  = ho[k];
      send(k, data, first, $sformatf("rand%0d_r%0d", it, 1 << k));
      wait_hash(k, 64 / (1 << k) + 1, exp_h, prev, junk, $sformatf("rand%0d_r%0d", it, 1 << k));
      model_h[k] = exp_h;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
